dbgu_mem_arb: RTL and testbench

DBGU_MEM_ARB -- requirements
Module: dbgu_mem_arb

---
 rtl/dbgu_mem_arb.sv | 127 ++++++++++++
 tb/tb_dbgu_mem_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbgu_mem_arb.sv
// Two-requester memory arbiter: CPU and debug unit share one memory port.
// Round-robin on conflict, one access per cycle, responses one cycle later.
module dbgu_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            n_reset,

    input  logic            cpu_req,
    input  logic [AW-1:0]   cpu_adr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_wren,
    output logic            cpu_gnt,
    output logic            cpu_rvalid,
    output logic [DW-1:0]   cpu_rdata,

    input  logic            dbg_req,
    input  logic [AW-1:0]   dbg_adr,
    input  logic [DW-1:0]   dbg_wdata,
    input  logic [DW/8-1:0] dbg_wren,
    input  logic            dbg_lock,
    output logic            dbg_ack,
    output logic [DW-1:0]   dbg_rdata,

    output logic            mem_en,
    output logic [AW-1:0]   mem_adr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wren,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        PH_NONE,
        PH_CPU,
        PH_DBG
    } phase_e;

    phase_e        state_q;
    phase_e        state_d;
    logic          last_dbg_q;
    logic          last_dbg_d;
    logic          dbg_elig;
    logic          cpu_elig;
    logic          gnt_dbg;
    logic          gnt_cpu;
    logic [DW-1:0] dbg_rdata_q;

    // Debug holds dbg_req through its ack cycle, so it is
    // ineligible while its own data phase is outstanding.
    assign dbg_elig = dbg_req && (state_q != PH_DBG);
    assign cpu_elig = cpu_req && !dbg_lock;

    always_comb begin
        gnt_dbg = 1'b0;
        gnt_cpu = 1'b0;
        if (dbg_elig && cpu_elig) begin
            gnt_dbg = !last_dbg_q;
            gnt_cpu = last_dbg_q;
        end else begin
            gnt_dbg = dbg_elig;
            gnt_cpu = cpu_elig;
        end
    end

    always_comb begin
        state_d    = PH_NONE;
        last_dbg_d = last_dbg_q;
        unique case (1'b1)
            gnt_dbg: begin
                state_d    = PH_DBG;
                last_dbg_d = 1'b1;
            end
            gnt_cpu: begin
                state_d    = PH_CPU;
                last_dbg_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= PH_NONE;
            last_dbg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    // Latched on writes too: the memory returns data either way.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            dbg_rdata_q <= '0;
        end else if (state_q == PH_DBG) begin
            dbg_rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        mem_wren  = '0;
        unique case (1'b1)
            gnt_dbg: begin
                mem_adr   = dbg_adr;
                mem_wdata = dbg_wdata;
                mem_wren  = dbg_wren;
            end
            gnt_cpu: begin
                mem_adr   = cpu_adr;
                mem_wdata = cpu_wdata;
                mem_wren  = cpu_wren;
            end
            default: ;
        endcase
    end

    assign mem_en     = gnt_dbg || gnt_cpu;
    assign cpu_gnt    = gnt_cpu;
    assign cpu_rvalid = (state_q == PH_CPU);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_ack    = (state_q == PH_DBG);
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dbgu_mem_arb.sv
// Randomized bench for dbgu_mem_arb with a transaction-level model
// and a small word memory behind the arbiter.
module tb_dbgu_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wren = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_adr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [3:0]  dbg_wren = '0;
    logic        dbg_lock = 1'b0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_en;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dbgu_mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .n_reset(n_reset),
        .cpu_req(cpu_req), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_adr(dbg_adr),
        .dbg_wdata(dbg_wdata), .dbg_wren(dbg_wren),
        .dbg_lock(dbg_lock), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] w,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) o[8*b +: 8] = w[8*b +: 8];
        return o;
    endfunction

    // Memory: write-first, read data one cycle after mem_en.
    logic [31:0] ram [16] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            ram[mem_adr[5:2]] <= merge(ram[mem_adr[5:2]], mem_wdata, mem_wren);
            mem_rdata <= merge(ram[mem_adr[5:2]], mem_wdata, mem_wren);
        end
    end

    typedef enum {K_NONE, K_CPU, K_DBG} kind_e;
    kind_e       m_pend;
    logic [31:0] m_pend_data;
    logic        m_last_dbg;
    logic [31:0] m_dbg_rdata;
    logic [31:0] mm [16] = '{default: 32'h0};
    logic        e_gc, e_gd;

    int checks = 0;
    int errors = 0;
    int dwait = 0;
    logic        saw_gnt, saw_ack, saw_rvalid;
    logic [31:0] saw_wdata, saw_rdata, saw_adr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend      = K_NONE;
        m_pend_data = '0;
        m_last_dbg  = 1'b0;
        m_dbg_rdata = '0;
    endtask

    // Who is served this cycle: lone wanter wins, else whoever
    // was not served last.
    task automatic model_decide();
        logic want_d, want_c;
        want_d = dbg_req && (m_pend != K_DBG);
        want_c = cpu_req && !dbg_lock;
        if (want_d && want_c) begin
            e_gd = !m_last_dbg;
            e_gc = m_last_dbg;
        end else begin
            e_gd = want_d;
            e_gc = want_c;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        model_decide();
        ea = '0; ew = '0; eb = '0;
        if (e_gd) begin
            ea = dbg_adr; ew = dbg_wdata; eb = dbg_wren;
        end else if (e_gc) begin
            ea = cpu_adr; ew = cpu_wdata; eb = cpu_wren;
        end
        chk("cpu_gnt", cpu_gnt, e_gc);
        chk("mem_en", mem_en, e_gc | e_gd);
        chk("mem_adr", mem_adr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_wren", mem_wren, eb);
        chk("cpu_rvalid", cpu_rvalid, m_pend == K_CPU);
        chk("dbg_ack", dbg_ack, m_pend == K_DBG);
        if (m_pend == K_CPU) chk("cpu_rdata", cpu_rdata, m_pend_data);
        chk("dbg_rdata", dbg_rdata, m_dbg_rdata);
        if (n_reset && dbg_req && !dbg_lock) begin
            if (mem_en && !cpu_gnt) begin
                chk("dbg_wait_le2", dwait <= 2, 1);
                dwait = 0;
            end else dwait++;
        end else dwait = 0;
        if (dbg_ack) dwait = 0;
        saw_gnt    = cpu_gnt;
        saw_ack    = dbg_ack;
        saw_rvalid = cpu_rvalid;
        saw_rdata  = cpu_rdata;
        saw_wdata  = mem_wdata;
        saw_adr    = mem_adr;
    endtask

    task automatic model_advance();
        if (m_pend == K_DBG) m_dbg_rdata = m_pend_data;
        m_pend = K_NONE;
        if (e_gd) begin
            mm[dbg_adr[5:2]] = merge(mm[dbg_adr[5:2]], dbg_wdata, dbg_wren);
            m_pend_data = mm[dbg_adr[5:2]];
            m_pend = K_DBG;
            m_last_dbg = 1'b1;
        end else if (e_gc) begin
            mm[cpu_adr[5:2]] = merge(mm[cpu_adr[5:2]], cpu_wdata, cpu_wren);
            m_pend_data = mm[cpu_adr[5:2]];
            m_pend = K_CPU;
            m_last_dbg = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (n_reset) model_advance();
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        dbg_lock = 1'b0;
        model_reset();
        dwait = 0;
        #1;
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        step();
        n_reset = 1'b1;
        saw_gnt = 1'b0;
        saw_ack = 1'b0;
    endtask

    task automatic rand_drive();
        if (!cpu_req || saw_gnt) begin
            cpu_req   = ($urandom_range(0, 9) < 7);
            cpu_adr   = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
            cpu_wren  = $urandom_range(0, 1) ? 4'h0
                                             : 4'($urandom_range(1, 15));
        end
        if (dbg_req && saw_ack) dbg_req = 1'b0;
        if (!dbg_req && $urandom_range(0, 9) < 4) begin
            dbg_req   = 1'b1;
            dbg_adr   = 32'($urandom_range(0, 15)) << 2;
            dbg_wdata = $urandom;
            dbg_wren  = $urandom_range(0, 1) ? 4'h0
                                             : 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 31) == 0) dbg_lock = !dbg_lock;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Both request right after release: debug write first.
        dbg_req = 1'b1; dbg_adr = 32'h20;
        dbg_wdata = 32'hAABBCCDD; dbg_wren = 4'hF;
        cpu_req = 1'b1; cpu_adr = 32'h20;
        cpu_wdata = 32'h0; cpu_wren = 4'h0;
        step();
        chk("first_cpu_gnt", saw_gnt, 0);
        chk("first_mem_adr", saw_adr, 32'h20);
        chk("first_mem_wdata", saw_wdata, 32'hAABBCCDD);
        step();
        chk("second_cpu_gnt", saw_gnt, 1);
        chk("second_dbg_ack", saw_ack, 1);
        dbg_req = 1'b0; cpu_req = 1'b0;
        step();
        chk("cpu_rvalid_lit", saw_rvalid, 1);
        chk("cpu_rdata_lit", saw_rdata, 32'hAABBCCDD);

        // Debug read back.
        dbg_req = 1'b1; dbg_wren = 4'h0; dbg_wdata = 32'h0;
        step();
        step();
        chk("dbg_read_ack", saw_ack, 1);
        dbg_req = 1'b0;
        chk("dbg_rdata_lit", dbg_rdata, 32'hAABBCCDD);
        step();
        step();
        chk("dbg_rdata_held", dbg_rdata, 32'hAABBCCDD);

        // Reset during an outstanding debug access.
        dbg_req = 1'b1; dbg_adr = 32'h24;
        step();
        do_reset();
        step();
        chk("no_ack_after_rst", saw_ack, 0);
        chk("dbg_rdata_cleared", dbg_rdata, 0);

        // Lock: CPU starved, debug keeps working.
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_adr = 32'h20; cpu_wren = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (dbg_req && saw_ack) dbg_req = 1'b0;
            else if (!dbg_req) begin
                dbg_req = 1'b1;
                dbg_adr = 32'($urandom_range(0, 15)) << 2;
                dbg_wdata = $urandom;
                dbg_wren = 4'($urandom_range(0, 15));
            end
            step();
            chk("lock_cpu_gnt", saw_gnt, 0);
        end
        for (int i = 0; i < 10 && dbg_req; i++) begin
            if (saw_ack) dbg_req = 1'b0;
            else step();
        end
        chk("lock_dbg_done", dbg_req, 0);
        dbg_lock = 1'b0;
        step();
        chk("cpu_after_unlock", saw_gnt, 1);
        cpu_req = 1'b0;
        step();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            rand_drive();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
